sio_crc_framer: RTL and testbench



---
 rtl/sio_crc_pkg.sv | 37 +++
 rtl/sio_crc_lfsr.sv | 33 +++
 rtl/sio_crc_framer.sv | 152 +++++++++++++++
 tb/tb_sio_crc_framer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sio_crc_pkg.sv
// rtl/sio_crc_pkg.sv - shared state type, default constants and CRC step for the sio CRC framer
package sio_crc_pkg;

    typedef enum logic [1:0] {
        PAY  = 2'd0,
        SKIP = 2'd1,
        CRC  = 2'd2
    } state_t;

    localparam logic [15:0] SIO_POLY16 = 16'h8005;
    localparam logic [15:0] SIO_INIT16 = 16'hFFFF;
    localparam int          CRC_MAX    = 32;
    localparam int          DW_MAX     = 32;

    // Bit-serial CRC over the low dw bits of data, MSB first; unrolls fully for constant widths.
    function automatic logic [CRC_MAX-1:0] crc_step(
        input logic [CRC_MAX-1:0] crc,
        input logic [DW_MAX-1:0]  data,
        input int                 crc_w,
        input int                 dw,
        input logic [CRC_MAX-1:0] poly
    );
        logic [CRC_MAX-1:0] v;
        logic [CRC_MAX-1:0] mask;
        logic               fb;
        v    = crc;
        mask = {CRC_MAX{1'b1}} >> (CRC_MAX - crc_w);
        for (int i = DW_MAX - 1; i >= 0; i--) begin
            if (i < dw) begin
                fb = v[crc_w-1] ^ data[i];
                v  = ((v << 1) ^ (fb ? poly : '0)) & mask;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/sio_crc_lfsr.sv
// rtl/sio_crc_lfsr.sv - CRC register advancing DW bits per enabled cycle, reloaded to INIT on clr
module sio_crc_lfsr
    import sio_crc_pkg::*;
#(
    parameter int               CRC_W = 16,
    parameter int               DW    = 4,
    parameter logic [CRC_W-1:0] POLY  = SIO_POLY16,
    parameter logic [CRC_W-1:0] INIT  = SIO_INIT16
) (
    input  logic             c,
    input  logic             r,
    input  logic             clr,
    input  logic             ce,
    input  logic [DW-1:0]    di,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] w_next;

    assign w_next = CRC_W'(crc_step(CRC_MAX'(r_crc), DW_MAX'(di), CRC_W, DW, CRC_MAX'(POLY)));

    always_ff @(posedge c) begin
        if (r || clr) begin
            r_crc <= INIT;
        end else if (ce) begin
            r_crc <= w_next;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/sio_crc_framer.sv
// rtl/sio_crc_framer.sv - fixed-length frame CRC append (TX) / check (RX); SIO_CRC_ERRCNT_EN adds err_count
module sio_crc_framer
    import sio_crc_pkg::*;
#(
    parameter int               DW         = 4,
    parameter int               CRC_W      = 16,
    parameter logic [CRC_W-1:0] POLY       = SIO_POLY16,
    parameter logic [CRC_W-1:0] INIT       = SIO_INIT16,
    parameter int               PAY_WORDS  = 24,
    parameter int               SKIP_WORDS = 1,
    parameter int               CHECK      = 0
) (
    input  logic          c,
    input  logic          r,
    input  logic          abort,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          done,
    output logic          crc_ok
`ifdef SIO_CRC_ERRCNT_EN
    ,
    output logic [15:0]   err_count
`endif
);

    localparam int CRC_WORDS = CRC_W / DW;
    localparam int MAX_A     = (PAY_WORDS > SKIP_WORDS) ? PAY_WORDS : SKIP_WORDS;
    localparam int MAX_SEG   = (MAX_A > CRC_WORDS) ? MAX_A : CRC_WORDS;
    localparam int CNT_W     = (MAX_SEG > 1) ? $clog2(MAX_SEG) : 1;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_seg_end;
    logic [CRC_W-1:0] w_crc, w_crc_sh;
    logic [DW-1:0]    w_crc_word, r_m_data;
    logic             w_tx_emit, w_out_free, w_acc, w_adv, w_seg_last;
    logic             w_frame_end, w_mis, w_clr, w_ce;
    logic             r_m_valid, r_m_last, r_done, r_crc_ok, r_err;

    always_comb begin
        w_seg_end = CNT_W'(PAY_WORDS - 1);
        case (r_state)
            SKIP:    w_seg_end = CNT_W'(SKIP_WORDS - 1);
            CRC:     w_seg_end = CNT_W'(CRC_WORDS - 1);
            default: w_seg_end = CNT_W'(PAY_WORDS - 1);
        endcase
    end

    // TX CRC emission sources the output register from the CRC, so input is held off then.
    assign w_tx_emit   = (CHECK == 0) && (r_state == CRC);
    assign w_out_free  = !r_m_valid || m_ready;
    assign s_ready     = w_out_free && !w_tx_emit;
    assign w_acc       = s_valid && s_ready && !abort;
    assign w_adv       = w_tx_emit ? (w_out_free && !abort) : w_acc;
    assign w_seg_last  = (r_cnt == w_seg_end);
    assign w_frame_end = w_adv && w_seg_last && (r_state == CRC);

    // The CRC register stays frozen in CRC state; the word counter selects the slice instead.
    assign w_crc_sh    = w_crc << (DW * r_cnt);
    assign w_crc_word  = DW'(w_crc_sh >> (CRC_W - DW));
    assign w_mis       = (CHECK != 0) && (s_data != w_crc_word);
    assign w_clr       = abort || w_frame_end;
    assign w_ce        = w_acc && (r_state == PAY);

    sio_crc_lfsr #(
        .CRC_W (CRC_W),
        .DW    (DW),
        .POLY  (POLY),
        .INIT  (INIT)
    ) u_lfsr (
        .c   (c),
        .r   (r),
        .clr (w_clr),
        .ce  (w_ce),
        .di  (s_data),
        .crc (w_crc)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = PAY;
        end else if (w_adv && w_seg_last) begin
            case (r_state)
                PAY:     w_state_nxt = (SKIP_WORDS == 0) ? CRC : SKIP;
                SKIP:    w_state_nxt = CRC;
                default: w_state_nxt = PAY;
            endcase
        end
    end

    always_ff @(posedge c) begin
        if (r) begin
            r_state   <= PAY;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_crc_ok  <= 1'b1;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_frame_end;
            if (abort || (w_adv && w_seg_last)) begin
                r_cnt <= '0;
            end else if (w_adv) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_clr) begin
                r_err <= 1'b0;
            end else if (w_acc && (r_state == CRC) && w_mis) begin
                r_err <= 1'b1;
            end
            if (w_frame_end && (CHECK != 0)) begin
                r_crc_ok <= !(r_err || w_mis);
            end
            if (w_adv) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_tx_emit ? w_crc_word : s_data;
                r_m_last  <= (r_state == CRC) && w_seg_last;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;
    assign done    = r_done;
    assign crc_ok  = r_crc_ok;

`ifdef SIO_CRC_ERRCNT_EN
    logic [15:0] r_err_count;

    always_ff @(posedge c) begin
        if (r) begin
            r_err_count <= '0;
        end else if (w_frame_end && (CHECK != 0) && (r_err || w_mis) && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_sio_crc_framer.sv
// tb/tb_sio_crc_framer.sv - scoreboard bench for sio_crc_framer: TX, RX table, abort, backpressure, loopback, DW=8
`timescale 1ns/1ps
module tb_sio_crc_framer;

    typedef struct { logic [7:0] d; logic last; } exp_t;
    typedef struct { int cw; int cb; logic ok; } vec_t;

    logic c = 1'b0;
    logic r = 1'b1;
    always #5 c = ~c;

    int checks = 0;
    int failures = 0;
    int tx_dones = 0, rx_dones = 0, p8_dones = 0, rx_words = 0, exp_err = 0;
    exp_t tx_q[$], rx_q[$], p8_q[$];
    vec_t vt[6];

    logic       tx_abort = 1'b0, tx_s_valid = 1'b0;
    logic [3:0] tx_s_data = 4'h0;
    logic       tx_s_ready, tx_m_valid, tx_m_ready, tx_m_last, tx_done, tx_crc_ok;
    logic [3:0] tx_m_data;

    logic       rx_abort = 1'b0, rx_m_ready = 1'b1, rx_drv_valid = 1'b0;
    logic [3:0] rx_drv_data = 4'h0;
    logic       rx_s_valid, rx_s_ready, rx_m_valid, rx_m_last, rx_done, rx_crc_ok;
    logic [3:0] rx_s_data, rx_m_data;

    logic       p8_abort = 1'b0, p8_s_valid = 1'b0, p8_m_ready = 1'b1;
    logic [7:0] p8_s_data = 8'h0;
    logic       p8_s_ready, p8_m_valid, p8_m_last, p8_done, p8_crc_ok;
    logic [7:0] p8_m_data;

    logic loop_mode = 1'b0, bp_en = 1'b0, bp_ready = 1'b1;

`ifdef SIO_CRC_ERRCNT_EN
    logic [15:0] tx_err_count, rx_err_count, p8_err_count;
`endif

    assign tx_m_ready = loop_mode ? rx_s_ready : bp_ready;
    assign rx_s_valid = loop_mode ? tx_m_valid : rx_drv_valid;
    assign rx_s_data  = loop_mode ? tx_m_data  : rx_drv_data;

    sio_crc_framer #(.CHECK(0)) u_tx (
        .c(c), .r(r), .abort(tx_abort), .s_valid(tx_s_valid), .s_ready(tx_s_ready), .s_data(tx_s_data),
        .m_valid(tx_m_valid), .m_ready(tx_m_ready), .m_data(tx_m_data), .m_last(tx_m_last),
        .done(tx_done), .crc_ok(tx_crc_ok)
`ifdef SIO_CRC_ERRCNT_EN
        , .err_count(tx_err_count)
`endif
    );

    sio_crc_framer #(.CHECK(1)) u_rx (
        .c(c), .r(r), .abort(rx_abort), .s_valid(rx_s_valid), .s_ready(rx_s_ready), .s_data(rx_s_data),
        .m_valid(rx_m_valid), .m_ready(rx_m_ready), .m_data(rx_m_data), .m_last(rx_m_last),
        .done(rx_done), .crc_ok(rx_crc_ok)
`ifdef SIO_CRC_ERRCNT_EN
        , .err_count(rx_err_count)
`endif
    );

    sio_crc_framer #(.DW(8), .PAY_WORDS(12), .SKIP_WORDS(0), .CHECK(0)) u_p8 (
        .c(c), .r(r), .abort(p8_abort), .s_valid(p8_s_valid), .s_ready(p8_s_ready), .s_data(p8_s_data),
        .m_valid(p8_m_valid), .m_ready(p8_m_ready), .m_data(p8_m_data), .m_last(p8_m_last),
        .done(p8_done), .crc_ok(p8_crc_ok)
`ifdef SIO_CRC_ERRCNT_EN
        , .err_count(p8_err_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_crc(input bit b[$]);
        logic [15:0] v;
        logic        fb;
        v = 16'hFFFF;
        foreach (b[i]) begin
            fb = v[15] ^ b[i];
            v  = {v[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return v;
    endfunction

    always @(posedge c) begin
        #1 bp_ready = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    logic       tx_stall = 1'b0;
    logic [4:0] tx_hold = 5'h0;
    always @(negedge c) begin : mon_tx
        exp_t e;
        if (!r) begin
            if (tx_stall) begin
                chk("tx_hold_valid", tx_m_valid, 1);
                chk("tx_hold_data", {tx_m_data, tx_m_last}, tx_hold);
            end
            if (tx_m_valid && tx_m_ready) begin
                if (tx_q.size() == 0) chk("tx_extra_word", 1, 0);
                else begin
                    e = tx_q.pop_front();
                    chk("tx_m_data", tx_m_data, e.d);
                    chk("tx_m_last", tx_m_last, e.last);
                end
            end
            tx_stall = tx_m_valid && !tx_m_ready;
            tx_hold  = {tx_m_data, tx_m_last};
        end
    end

    always @(negedge c) begin : mon_rx
        exp_t e;
        if (!r && rx_m_valid && rx_m_ready) begin
            if (rx_q.size() == 0) chk("rx_extra_word", 1, 0);
            else begin
                e = rx_q.pop_front();
                chk("rx_m_data", rx_m_data, e.d);
                chk("rx_m_last", rx_m_last, e.last);
            end
            rx_words++;
            if (rx_m_last) begin
                if (loop_mode) chk("rx_last_spacing", rx_words, 29);
                rx_words = 0;
            end
        end
    end

    always @(negedge c) begin : mon_p8
        exp_t e;
        if (!r && p8_m_valid && p8_m_ready) begin
            if (p8_q.size() == 0) chk("p8_extra_word", 1, 0);
            else begin
                e = p8_q.pop_front();
                chk("p8_m_data", p8_m_data, e.d);
                chk("p8_m_last", p8_m_last, e.last);
            end
        end
    end

    always @(negedge c) begin : mon_done
        if (!r) begin
            if (tx_done) tx_dones++;
            if (p8_done) p8_dones++;
            if (rx_done) begin
                rx_dones++;
                if (loop_mode) chk("loop_crc_ok", rx_crc_ok, 1);
            end
        end
    end

    task automatic tx_put(input logic [3:0] d);
        int n;
        n = 0; tx_s_valid = 1'b1; tx_s_data = d;
        @(negedge c);
        while (!tx_s_ready && n < 500) begin n++; @(negedge c); end
        if (n >= 500) chk("tx_put_timeout", 1, 0);
        @(posedge c); #1; tx_s_valid = 1'b0;
    endtask

    task automatic rx_put(input logic [3:0] d);
        int n;
        n = 0; rx_drv_valid = 1'b1; rx_drv_data = d;
        @(negedge c);
        while (!rx_s_ready && n < 500) begin n++; @(negedge c); end
        if (n >= 500) chk("rx_put_timeout", 1, 0);
        @(posedge c); #1; rx_drv_valid = 1'b0;
    endtask

    task automatic p8_put(input logic [7:0] d);
        int n;
        n = 0; p8_s_valid = 1'b1; p8_s_data = d;
        @(negedge c);
        while (!p8_s_ready && n < 500) begin n++; @(negedge c); end
        if (n >= 500) chk("p8_put_timeout", 1, 0);
        @(posedge c); #1; p8_s_valid = 1'b0;
    endtask

    task automatic tx_frame(input logic to_rx);
        logic [3:0]  w;
        logic [15:0] crc;
        bit          bq[$];
        int          n;
        for (int i = 0; i < 25; i++) begin
            w = 4'($urandom_range(0, 15));
            if (i < 24) for (int j = 3; j >= 0; j--) bq.push_back(w[j]);
            tx_q.push_back(exp_t'{8'(w), 1'b0});
            if (to_rx) rx_q.push_back(exp_t'{8'(w), 1'b0});
            tx_put(w);
        end
        crc = ref_crc(bq);
        for (int k = 0; k < 4; k++) begin
            tx_q.push_back(exp_t'{8'(crc[15-4*k -: 4]), k == 3});
            if (to_rx) rx_q.push_back(exp_t'{8'(crc[15-4*k -: 4]), k == 3});
        end
        n = 0;
        @(negedge c);
        while (!(tx_m_valid && tx_m_last) && n < 500) begin
            chk("tx_s_ready_in_crc", tx_s_ready, 0);
            n++;
            @(negedge c);
        end
        if (n >= 500) chk("tx_crc_timeout", 1, 0);
        @(posedge c); #1;
    endtask

    task automatic rx_frame(input int cw, input int cb, input logic exp_ok);
        logic [3:0]  w[29];
        logic [15:0] crc;
        bit          bq[$];
        for (int i = 0; i < 25; i++) w[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 24; i++) for (int j = 3; j >= 0; j--) bq.push_back(w[i][j]);
        crc = ref_crc(bq);
        for (int k = 0; k < 4; k++) w[25+k] = crc[15-4*k -: 4];
        if (cw >= 0) w[cw][cb] = ~w[cw][cb];
        for (int i = 0; i < 29; i++) begin
            rx_q.push_back(exp_t'{8'(w[i]), i == 28});
            rx_put(w[i]);
        end
        @(negedge c);
        chk("rx_done_pulse", rx_done, 1);
        chk("rx_crc_ok", rx_crc_ok, exp_ok);
        if (!exp_ok) exp_err++;
`ifdef SIO_CRC_ERRCNT_EN
        chk("rx_err_count", rx_err_count, exp_err);
`endif
        @(posedge c); #1;
    endtask

    task automatic p8_frame();
        logic [7:0]  w;
        logic [15:0] crc;
        bit          bq[$];
        for (int i = 0; i < 12; i++) begin
            w = 8'($urandom_range(0, 255));
            for (int j = 7; j >= 0; j--) bq.push_back(w[j]);
            p8_q.push_back(exp_t'{w, 1'b0});
            p8_put(w);
        end
        crc = ref_crc(bq);
        p8_q.push_back(exp_t'{crc[15:8], 1'b0});
        p8_q.push_back(exp_t'{crc[7:0], 1'b1});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((tx_q.size() != 0 || rx_q.size() != 0 || p8_q.size() != 0) && n < 1000) begin
            @(posedge c); n++;
        end
        if (n >= 1000) chk("drain_timeout", 1, 0);
        repeat (2) @(posedge c);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] w;
        vt[0] = vec_t'{-1, 0, 1'b1};
        vt[1] = vec_t'{5, 2, 1'b0};
        vt[2] = vec_t'{24, 0, 1'b1};
        vt[3] = vec_t'{25, 3, 1'b0};
        vt[4] = vec_t'{28, 0, 1'b0};
        vt[5] = vec_t'{-1, 0, 1'b1};

        repeat (3) @(posedge c);
        @(negedge c);
        chk("rst_tx_m_valid", tx_m_valid, 0);
        chk("rst_tx_m_data", tx_m_data, 0);
        chk("rst_tx_m_last", tx_m_last, 0);
        chk("rst_tx_done", tx_done, 0);
        chk("rst_tx_crc_ok", tx_crc_ok, 1);
        chk("rst_rx_m_valid", rx_m_valid, 0);
        chk("rst_rx_crc_ok", rx_crc_ok, 1);
        chk("rst_p8_m_valid", p8_m_valid, 0);
`ifdef SIO_CRC_ERRCNT_EN
        chk("rst_err_count", rx_err_count, 0);
`endif
        @(posedge c); #1; r = 1'b0;

        repeat (3) tx_frame(1'b0);
        bp_en = 1'b1;
        repeat (5) tx_frame(1'b0);
        bp_en = 1'b0;
        drain();

        for (int i = 0; i < 10; i++) begin
            w = 4'($urandom_range(0, 15));
            tx_q.push_back(exp_t'{8'(w), 1'b0});
            tx_put(w);
        end
        tx_abort = 1'b1; tx_s_valid = 1'b1; tx_s_data = 4'hA;
        @(posedge c); #1;
        tx_abort = 1'b0; tx_s_valid = 1'b0;
        tx_frame(1'b0);
        drain();

        for (int i = 0; i < 7; i++) begin
            w = 4'($urandom_range(0, 15));
            tx_q.push_back(exp_t'{8'(w), 1'b0});
            tx_put(w);
        end
        @(posedge c); #1; r = 1'b1;
        @(posedge c); #1; r = 1'b0;
        @(negedge c);
        chk("midreset_m_valid", tx_m_valid, 0);
        chk("midreset_s_ready", tx_s_ready, 1);
        @(posedge c); #1;
        tx_frame(1'b0);
        drain();

        for (int i = 0; i < 6; i++) rx_frame(vt[i].cw, vt[i].cb, vt[i].ok);

        for (int i = 0; i < 10; i++) begin
            w = 4'($urandom_range(0, 15));
            rx_q.push_back(exp_t'{8'(w), 1'b0});
            rx_put(w);
        end
        rx_abort = 1'b1; rx_drv_valid = 1'b1; rx_drv_data = 4'h5;
        @(posedge c); #1;
        rx_abort = 1'b0; rx_drv_valid = 1'b0;
        rx_frame(-1, 0, 1'b1);

        repeat (3) p8_frame();
        drain();

        loop_mode = 1'b1;
        repeat (1000) tx_frame(1'b1);
        drain();
        loop_mode = 1'b0;

        chk("tx_q_empty", tx_q.size(), 0);
        chk("rx_q_empty", rx_q.size(), 0);
        chk("p8_q_empty", p8_q.size(), 0);
        chk("tx_done_count", tx_dones, 1010);
        chk("rx_done_count", rx_dones, 1007);
        chk("p8_done_count", p8_dones, 3);
`ifdef SIO_CRC_ERRCNT_EN
        chk("final_err_count", rx_err_count, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
